// File: rtl/dmem_dual_port_arbiter.sv
// dmem_dual_port_arbiter: round-robin arbiter serialising two CPU load/store ports onto one word memory
module dmem_dual_port_arbiter #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [1:0]  mem_read_i,
    input  logic [1:0]  mem_write_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] data_i,
    output logic [1:0]  stall_o,
    output logic [63:0] data_o,
    output logic [1:0]  rvalid_o,
    output logic [1:0]  err_o
);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              gp;
    logic              rr_last_q;
    logic              rr_last_d;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_rd;
    logic              sel_wr;
    logic              bad_addr;
    logic              illegal;
    logic [ADDR_W-1:0] word;
    logic              we;
    logic [31:0]       rdata;
    logic [31:0]       mem_q [DEPTH];
    logic [63:0]       data_q;
    logic [63:0]       data_d;
    logic [1:0]        rvalid_q;
    logic [1:0]        rvalid_d;
    logic [1:0]        err_q;
    logic [1:0]        err_d;

    // Lone requester wins; on contention the port that was not served last wins
    always_comb begin
        req       = mem_read_i | mem_write_i;
        grant     = (req == 2'b11) ? (rr_last_q ? 2'b01 : 2'b10) : req;
        gp        = grant[1];
        rr_last_d = (|grant) ? gp : rr_last_q;
    end

    assign stall_o = req & ~grant;

    // Decode the granted port's request; bad addresses never touch the array
    always_comb begin
        sel_addr  = gp ? addr_i[63:32] : addr_i[31:0];
        sel_wdata = gp ? data_i[63:32] : data_i[31:0];
        sel_rd    = mem_read_i[gp];
        sel_wr    = mem_write_i[gp];
        word      = sel_addr[ADDR_W+1:2];
        bad_addr  = (sel_addr[1:0] != 2'b00) || (sel_addr >= LIMIT);
        illegal   = sel_rd & sel_wr;
        we        = (|grant) & sel_wr & ~bad_addr;
        rdata     = bad_addr ? 32'd0 : mem_q[word];
    end

    // Read+write together counts as a store; only pure loads return data
    always_comb begin
        rvalid_d = grant & {2{sel_rd & ~sel_wr}};
        err_d    = grant & {2{bad_addr | illegal}};
        data_d   = data_q;
        if (rvalid_d[1]) data_d[63:32] = rdata;
        if (rvalid_d[0]) data_d[31:0] = rdata;
    end

    // Arbitration pointer and per-port response registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b0;
            data_q    <= '0;
            rvalid_q  <= '0;
            err_q     <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            data_q    <= data_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    // Word array, cleared by reset so a CPU restart sees a zeroed memory
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[word] <= sel_wdata;
        end
    end

    assign data_o   = data_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_dmem_dual_port_arbiter.sv
// tb_dmem_dual_port_arbiter: directed and random checks of the arbiter against a word-array model
module tb_dmem_dual_port_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mem_read_i = '0;
    logic [1:0]  mem_write_i = '0;
    logic [63:0] addr_i = '0;
    logic [63:0] data_i = '0;
    logic [1:0]  stall_o;
    logic [63:0] data_o;
    logic [1:0]  rvalid_o;
    logic [1:0]  err_o;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mm [128];
    int          last;
    logic [31:0] ed1, ed0;
    logic [1:0]  ev, ee, es;
    logic [1:0]  prd, pwr;
    logic [31:0] pa [2];
    logic [31:0] pd [2];

    dmem_dual_port_arbiter dut (
        .clk_i(clk_i), .rst_n(rst_n), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .data_i(data_i), .stall_o(stall_o), .data_o(data_o),
        .rvalid_o(rvalid_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mm[i] = '0;
        last = 0;
        ed1 = '0;
        ed0 = '0;
        ev = '0;
        ee = '0;
        es = '0;
    endtask

    // One bus cycle starting at a negedge: drive, check stall, model the served request, check responses
    task automatic cycle(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a1,
                         input logic [31:0] a0, input logic [31:0] d1, input logic [31:0] d0);
        logic [1:0]  rq;
        int          win;
        logic [31:0] a, d;
        logic        b;
        mem_read_i = rd;
        mem_write_i = wr;
        addr_i = {a1, a0};
        data_i = {d1, d0};
        #1;
        rq = rd | wr;
        win = -1;
        if (rq == 2'b11) win = (last == 0) ? 1 : 0;
        else if (rq[1]) win = 1;
        else if (rq[0]) win = 0;
        es = rq;
        ev = '0;
        ee = '0;
        if (win >= 0) begin
            es[win] = 1'b0;
            a = win ? a1 : a0;
            d = win ? d1 : d0;
            b = (a % 4 != 0) || (a >= 512);
            if (wr[win]) begin
                if (!b) mm[a / 4] = d;
                ee[win] = b || rd[win];
            end else begin
                ev[win] = 1'b1;
                ee[win] = b;
                if (win == 1) ed1 = b ? 32'd0 : mm[a / 4];
                else ed0 = b ? 32'd0 : mm[a / 4];
            end
            last = win;
        end
        chk("stall", {62'd0, stall_o}, {62'd0, es});
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rvalid", {62'd0, rvalid_o}, {62'd0, ev});
        chk("err", {62'd0, err_o}, {62'd0, ee});
        chk("data", data_o, {ed1, ed0});
    endtask

    // Directed scenarios followed by random traffic with CPUs holding stalled requests
    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_rvalid", {62'd0, rvalid_o}, 64'd0);
        chk("rst_data", data_o, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_stall", {62'd0, stall_o}, 64'd0);
        chk("rel_err", {62'd0, err_o}, 64'd0);
        @(negedge clk_i);
        for (int i = 0; i < 128; i++) cycle(2'b10, 2'b00, 32'(i * 4), 0, 0, 0);
        cycle(2'b00, 2'b10, 32'd8, 0, 32'hAB, 0);
        cycle(2'b10, 2'b00, 32'd8, 0, 0, 0);
        cycle(2'b01, 2'b00, 0, 32'd8, 0, 0);
        cycle(2'b11, 2'b00, 32'd8, 32'd8, 0, 0);
        cycle(2'b01, 2'b00, 32'd8, 32'd8, 0, 0);
        cycle(2'b11, 2'b00, 32'd8, 32'd8, 0, 0);
        cycle(2'b01, 2'b00, 32'd8, 32'd8, 0, 0);
        cycle(2'b10, 2'b00, 32'd0, 0, 0, 0);
        cycle(2'b10, 2'b01, 32'd12, 32'd12, 0, 32'd5);
        cycle(2'b10, 2'b00, 32'd12, 0, 0, 0);
        cycle(2'b00, 2'b01, 0, 32'd4, 0, 32'h1111);
        cycle(2'b00, 2'b01, 0, 32'd6, 0, 32'hDEAD);
        cycle(2'b01, 2'b00, 0, 32'd4, 0, 0);
        cycle(2'b10, 2'b00, 32'd512, 0, 0, 0);
        cycle(2'b10, 2'b10, 32'd16, 0, 32'hCAFE, 0);
        cycle(2'b01, 2'b00, 0, 32'd16, 0, 0);
        cycle(2'b00, 2'b10, 32'd40, 0, 32'h1234, 0);
        mem_read_i = 2'b10;
        mem_write_i = 2'b00;
        addr_i = {32'd40, 32'd0};
        #2 rst_n = 1'b0;
        #1 chk("midrst_rvalid", {62'd0, rvalid_o}, 64'd0);
        @(posedge clk_i);
        #1 chk("midrst_hold", {62'd0, rvalid_o}, 64'd0);
        @(negedge clk_i);
        mem_read_i = '0;
        rst_n = 1'b1;
        model_reset();
        #1 chk("midrst_data", data_o, 64'd0);
        @(negedge clk_i);
        cycle(2'b10, 2'b00, 32'd40, 0, 0, 0);
        prd = '0;
        pwr = '0;
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!es[p]) begin
                    int k;
                    k = $urandom_range(0, 9);
                    prd[p] = (k >= 3 && k <= 5) || k == 9;
                    pwr[p] = k >= 6;
                    pa[p] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 15) * 4;
                    pd[p] = $urandom;
                end
            end
            cycle(prd, pwr, pa[1], pa[0], pd[1], pd[0]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
